// File: rtl/stack_pkg.sv
// stack_pkg: shared op/state types and default sizes for the stack arbiter.
package stack_pkg;
    typedef enum logic {OP_PUSH = 1'b0, OP_POP = 1'b1} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_FLUSH} state_e;
    localparam int DATA_WIDTH = 8;
    localparam int LIFO_SIZE = 20;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; search starts after the last granted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 adv,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id
);
    localparam int W = $clog2(N);
    logic [W-1:0] ptr_q, ptr_d, idx;
    always_comb begin
        gnt = '0;
        gnt_id = '0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(ptr_q) + k) % N);
            if (req[idx] && gnt == '0) begin
                gnt[idx] = 1'b1;
                gnt_id = idx;
            end
        end
        ptr_d = adv ? gnt_id : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= W'(N - 1);
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one external stack among NUM_REQ requesters, one op in flight.
module stack_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = stack_pkg::DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    input  logic                          rsp_ready,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic [DATA_WIDTH-1:0]         stk_entry,
    output logic                          stk_insert,
    output logic                          stk_pop,
    input  logic [DATA_WIDTH-1:0]         stk_head,
    input  logic                          stk_full,
    input  logic                          stk_empty
);
    import stack_pkg::*;
    localparam int IW = $clog2(NUM_REQ);
    state_e state_q, state_d;
    op_e op_q;
    logic [IW-1:0] id_q, gnt_id;
    logic [DATA_WIDTH-1:0] data_q, rsp_data_q, rsp_data_d;
    logic rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0] gnt;
    logic idle_ok, accept, issue_push, issue_pop;
    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk(clk), .rst(rst), .req(req_valid), .adv(accept), .gnt(gnt), .gnt_id(gnt_id)
    );
    // Every output is gated with rst so nothing leaks during the reset cycle itself.
    always_comb begin
        idle_ok = state_q == S_IDLE && !rst && !flush_req;
        accept = idle_ok && |req_valid;
        req_ready = idle_ok ? gnt : '0;
        issue_push = !rst && state_q == S_ISSUE && op_q == OP_PUSH && !stk_full;
        issue_pop = !rst && state_q == S_ISSUE && op_q == OP_POP && !stk_empty;
        stk_insert = issue_push;
        stk_entry = issue_push ? data_q : '0;
        stk_pop = issue_pop || (!rst && state_q == S_FLUSH && !stk_empty);
        flush_done = !rst && state_q == S_FLUSH && stk_empty;
        rsp_valid = !rst && state_q == S_RESP;
        rsp_id = rsp_valid ? id_q : '0;
        rsp_data = rsp_valid ? rsp_data_q : '0;
        rsp_err = rsp_valid && rsp_err_q;
        rsp_data_d = issue_pop ? stk_head : '0;
        rsp_err_d = op_q == OP_PUSH ? stk_full : stk_empty;
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = flush_req ? S_FLUSH : (|req_valid ? S_ISSUE : S_IDLE);
            S_ISSUE: state_d = S_RESP;
            S_RESP:  state_d = rsp_ready ? S_IDLE : S_RESP;
            S_FLUSH: state_d = stk_empty ? S_IDLE : S_FLUSH;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q <= OP_PUSH;
            id_q <= '0;
            data_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q <= gnt_id;
                op_q <= op_e'(req_op[gnt_id]);
                data_q <= req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state_q == S_ISSUE) begin
                rsp_data_q <= rsp_data_d;
                rsp_err_q <= rsp_err_d;
            end
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed checks of the stack arbiter against a behavioral stack.
module tb_stack_arbiter;
    logic clk = 0, rst = 1, rsp_ready = 1, flush_req = 0, force_full = 0;
    logic [3:0] req_valid = 0, req_op = 0, req_ready;
    logic [31:0] req_data = 0;
    logic rsp_valid, rsp_err, flush_done, stk_insert, stk_pop, stk_full, stk_empty;
    logic [1:0] rsp_id;
    logic [7:0] rsp_data, stk_entry, stk_head;
    logic [7:0] mem [0:19];
    int cnt = 0, pop_cnt = 0, n_tests = 0, n_fail = 0;

    stack_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready), .flush_req(flush_req), .flush_done(flush_done),
        .stk_entry(stk_entry), .stk_insert(stk_insert), .stk_pop(stk_pop),
        .stk_head(stk_head), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    // Behavioral LIFO standing in for the external stack.
    assign stk_head = cnt > 0 ? mem[cnt-1] : 8'h00;
    assign stk_empty = cnt == 0;
    assign stk_full = cnt >= 20 || force_full;
    always @(posedge clk) begin
        if (stk_pop) pop_cnt <= pop_cnt + 1;
        if (rst) cnt <= 0;
        else if (stk_insert && cnt < 20) begin
            mem[cnt] <= stk_entry;
            cnt <= cnt + 1;
        end else if (stk_pop && cnt > 0) cnt <= cnt - 1;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic do_op(input int id, input logic op, input logic [7:0] d);
        int c;
        req_valid = 4'(1 << id);
        req_op[id] = op;
        req_data[id*8 +: 8] = d;
        #1;
        for (c = 0; c < 20 && req_ready[id] !== 1'b1; c++) tick();
        if (c == 20) begin
            n_tests++; n_fail++;
            $display("FAIL do_op_grant timeout id=%0d", id);
        end
        tick();
        req_valid = 0;
        for (c = 0; c < 20 && rsp_valid !== 1'b1; c++) tick();
        if (c == 20) begin
            n_tests++; n_fail++;
            $display("FAIL do_op_rsp timeout id=%0d", id);
        end
        tick();
    endtask

    task automatic test_reset;
        rst = 1;
        req_valid = 4'hF;
        tick();
        tick();
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_tests++; if ({stk_insert, stk_pop, flush_done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b exp 000", {stk_insert, stk_pop, flush_done}); end
        n_tests++; if ({rsp_id, rsp_data, rsp_err, stk_entry} !== 19'h0) begin n_fail++; $display("FAIL reset_payload got %h exp 0", {rsp_id, rsp_data, rsp_err, stk_entry}); end
        rst = 0;
        req_valid = 0;
    endtask

    task automatic test_basic;
        req_valid = 4'b0100; req_op = 0; req_data[16 +: 8] = 8'hA5;
        #1;
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL basic_grant2 got %b exp 0100", req_ready); end
        tick();
        req_valid = 0;
        n_tests++; if (stk_insert !== 1'b1 || stk_entry !== 8'hA5 || stk_pop !== 1'b0) begin n_fail++; $display("FAIL basic_insert got ins=%b entry=%h pop=%b exp 1 a5 0", stk_insert, stk_entry, stk_pop); end
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h00 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL basic_push_rsp got v=%b id=%0d d=%h e=%b exp 1 2 00 0", rsp_valid, rsp_id, rsp_data, rsp_err); end
        tick();
        req_valid = 4'b0010; req_op = 4'b0010;
        #1;
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL basic_grant1 got %b exp 0010", req_ready); end
        tick();
        req_valid = 0;
        n_tests++; if (stk_pop !== 1'b1 || stk_insert !== 1'b0) begin n_fail++; $display("FAIL basic_pop got pop=%b ins=%b exp 1 0", stk_pop, stk_insert); end
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'hA5 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL basic_pop_rsp got v=%b id=%0d d=%h e=%b exp 1 1 a5 0", rsp_valid, rsp_id, rsp_data, rsp_err); end
        tick();
        req_op = 0;
    endtask

    task automatic test_fairness;
        int c;
        do_reset();
        req_valid = 4'hF; req_op = 0; req_data = 32'h44332211;
        #1;
        for (int g = 0; g < 5; g++) begin
            for (c = 0; c < 10 && req_ready === 4'h0; c++) tick();
            n_tests++; if (req_ready !== 4'(1 << (g % 4))) begin n_fail++; $display("FAIL fair_grant%0d got %b exp %b", g, req_ready, 4'(1 << (g % 4))); end
            tick();
        end
        req_valid = 0;
        tick();
        tick();
    endtask

    task automatic test_errors;
        do_reset();
        req_valid = 4'b0001; req_op = 4'b0001;
        #1;
        tick();
        req_valid = 0;
        n_tests++; if (stk_pop !== 1'b0) begin n_fail++; $display("FAIL err_empty_pop got %b exp 0", stk_pop); end
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL err_empty_rsp got v=%b id=%0d e=%b d=%h exp 1 0 1 00", rsp_valid, rsp_id, rsp_err, rsp_data); end
        tick();
        force_full = 1;
        req_valid = 4'b0010; req_op = 0; req_data[8 +: 8] = 8'h77;
        #1;
        tick();
        req_valid = 0;
        n_tests++; if (stk_insert !== 1'b0) begin n_fail++; $display("FAIL err_full_insert got %b exp 0", stk_insert); end
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL err_full_rsp got v=%b id=%0d e=%b d=%h exp 1 1 1 00", rsp_valid, rsp_id, rsp_err, rsp_data); end
        tick();
        force_full = 0;
    endtask

    task automatic test_backpressure;
        rsp_ready = 0;
        req_valid = 4'b0100; req_op = 0; req_data[16 +: 8] = 8'h3C;
        #1;
        tick();
        req_valid = 4'b1000;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h00 || rsp_err !== 1'b0 || req_ready !== 4'h0) begin n_fail++; $display("FAIL bp_hold%0d got v=%b id=%0d d=%h e=%b rdy=%b exp 1 2 00 0 0000", i, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready); end
            tick();
        end
        rsp_ready = 1;
        #1;
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_handshake got %b exp 1", rsp_valid); end
        tick();
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b exp 0 1000", rsp_valid, req_ready); end
        req_valid = 0;
    endtask

    task automatic test_flush;
        int base, bad, done;
        do_reset();
        do_op(0, 1'b0, 8'h11);
        do_op(1, 1'b0, 8'h22);
        do_op(2, 1'b0, 8'h33);
        base = pop_cnt; bad = 0; done = 0;
        flush_req = 1; req_valid = 4'b0001; req_op = 0;
        #1;
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL flush_no_grant got %b exp 0000", req_ready); end
        tick();
        flush_req = 0;
        for (int c = 0; c < 10 && done == 0; c++) begin
            if (req_ready !== 4'h0) bad++;
            if (flush_done === 1'b1) done = 1;
            else tick();
        end
        n_tests++; if (done !== 1) begin n_fail++; $display("FAIL flush_done_seen got %0d exp 1", done); end
        n_tests++; if (pop_cnt - base !== 3) begin n_fail++; $display("FAIL flush_pops got %0d exp 3", pop_cnt - base); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL flush_grant_during got %0d exp 0", bad); end
        tick();
        n_tests++; if (flush_done !== 1'b0 || req_ready !== 4'b0001) begin n_fail++; $display("FAIL flush_after got done=%b rdy=%b exp 0 0001", flush_done, req_ready); end
        req_valid = 0;
        flush_req = 1;
        #1;
        tick();
        flush_req = 0;
        n_tests++; if (flush_done !== 1'b1 || stk_pop !== 1'b0) begin n_fail++; $display("FAIL flush_empty got done=%b pop=%b exp 1 0", flush_done, stk_pop); end
        tick();
    endtask

    task automatic test_reset_mid;
        rsp_ready = 0;
        req_valid = 4'b0010; req_op = 0; req_data[8 +: 8] = 8'h44;
        #1;
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_grant got %b exp 0010", req_ready); end
        tick();
        req_valid = 0;
        tick();
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_resp got %b exp 1", rsp_valid); end
        rst = 1;
        tick();
        n_tests++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || stk_entry !== 8'h00) begin n_fail++; $display("FAIL rmid_cleared got v=%b id=%0d entry=%h exp 0 0 00", rsp_valid, rsp_id, stk_entry); end
        rst = 0;
        rsp_ready = 1;
        req_valid = 4'hF;
        #1;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_regrant got %b exp 0001", req_ready); end
        req_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_errors();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one stack (2..8).
REQ-002 Parameter: DATA_WIDTH, default 8, entry width, equal to the attached stack's DATA_WIDTH.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 Port: req_op  input  NUM_REQ  per-requester op; 0 = push, 1 = pop.
REQ-007 Port: req_data  input  NUM_REQ*DATA_WIDTH  per-requester push data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: req_ready  output  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
REQ-009 Port: rsp_valid, rsp_id, rsp_data, rsp_err  output  1 / $clog2(NUM_REQ) / DATA_WIDTH / 1  completion: requester index, pop data, error flag.
REQ-010 Port: rsp_ready  input  1  response consumer ready.
REQ-011 Port: flush_req  input  1  level request to empty the stack; flush_done  output  1  one-cycle pulse on flush completion.
REQ-012 Port: stk_entry, stk_insert, stk_pop  output  DATA_WIDTH / 1 / 1  stack write data and controls.
REQ-013 Port: stk_head, stk_full, stk_empty  input  DATA_WIDTH / 1 / 1  stack top-of-stack and status.

Function
REQ-014 FSM states IDLE, ISSUE, RESP, FLUSH; one transaction in flight at a time.
REQ-015 IDLE: if flush_req=1, go to FLUSH with req_ready=0; else if any req_valid, assert req_ready for exactly one requester chosen round-robin, latch id/op/data, go to ISSUE; otherwise remain in IDLE.
REQ-016 Round-robin: search starts at last-granted index + 1, modulo NUM_REQ; pointer updates only on acceptance.
REQ-017 req_ready is 0 in every state except IDLE, and is 0 in IDLE when flush_req=1.
REQ-018 ISSUE (one cycle): push with stk_full=0 asserts stk_insert=1, stk_entry=latched data; pop with stk_empty=0 asserts stk_pop=1 and captures stk_head into rsp_data; then go to RESP.
REQ-019 ISSUE push with stk_full=1: no stk_insert, rsp_err=1. Pop with stk_empty=1: no stk_pop, rsp_err=1, rsp_data=0.
REQ-020 stk_insert and stk_pop SHALL never be 1 in the same cycle and SHALL be 1 only in ISSUE or FLUSH.
REQ-021 RESP: rsp_valid=1 with stable rsp_id/rsp_data/rsp_err until rsp_ready=1; return to IDLE in the cycle after the handshake.
REQ-022 Push responses carry rsp_data=0; rsp_err=0 on success.
REQ-023 Latency: acceptance in cycle T -> stack control in T+1 -> rsp_valid from T+2; peak throughput is one operation per 3 cycles.
REQ-024 FLUSH: stk_pop=stk_empty ? 0 : 1 each cycle; when stk_empty=1, pulse flush_done for one cycle and return to IDLE; flush on an already-empty stack completes in one cycle.
REQ-025 flush_req deasserting mid-FLUSH has no effect; the flush runs to completion.

Reset
REQ-026 rst=1 at a clock edge returns the FSM to IDLE, sets the round-robin pointer to NUM_REQ-1 (requester 0 first), and clears all latched command state, aborting any in-flight operation.
REQ-027 During and after reset, outputs are 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, flush_done, stk_entry, stk_insert, stk_pop.

Structure
REQ-028 Package stack_pkg holds the op typedef (OP_PUSH=0, OP_POP=1), the FSM state enum, and shared default constants DATA_WIDTH=8, LIFO_SIZE=20.
REQ-029 Round-robin selection is the sub-module rr_arbiter (request vector, advance enable -> one-hot grant).
REQ-030 The block contains no storage for stack data; the stack instance is external.

Verification
REQ-031 Basic: after reset, requester 2 pushes 0xA5, then requester 1 pops -> stk_insert pulse with entry 0xA5; pop response rsp_id=1, rsp_data=0xA5, rsp_err=0.
REQ-032 Fairness: all 4 requesters hold push valid continuously -> grants in order 0,1,2,3,0.
REQ-033 Errors: pop on empty stack -> rsp_err=1, rsp_data=0, no stk_pop. Push when stk_full=1 -> rsp_err=1, no stk_insert.
REQ-034 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and payload held stable, req_ready=0 throughout; completes one cycle after rsp_ready=1.
REQ-035 Flush: push 3 entries, assert flush_req together with req_valid[0] -> no grant, exactly 3 stk_pop pulses, then flush_done pulse, then requester 0 granted.
REQ-036 Reset mid-operation: rst=1 in RESP -> next cycle rsp_valid=0, FSM in IDLE, next grant goes to requester 0.
